// File: rtl/mines_pkg.sv
// Shared definitions for the mine placer: one-hot state encoding and
// Galois LFSR tap constants.
package mines_pkg;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_GEN   = 5'b00010;
    localparam logic [4:0] ST_CHECK = 5'b00100;
    localparam logic [4:0] ST_WRITE = 5'b01000;
    localparam logic [4:0] ST_DONE  = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE  = ST_IDLE,
        S_GEN   = ST_GEN,
        S_CHECK = ST_CHECK,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE
    } state_t;

    // Maximal-length right-shifting Galois taps; 0 means unsupported width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0007_2000;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// Seedable Galois LFSR; a zero seed would lock up, so it loads as 1.
module mine_lfsr
    import mines_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= WIDTH'(1);
        end else if (load) begin
            value <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/place_mines_safe.sv
// Places a clamped number of mines at LFSR-chosen cells, skipping an optional
// safe square around the first click, with a bounded number of draws.
module place_mines_safe
    import mines_pkg::*;
#(
    parameter  int BOARD_WIDTH  = 8,
    parameter  int BOARD_HEIGHT = 8,
    parameter  int LFSR_WIDTH   = 16,
    parameter  int SAFE_RADIUS  = 1,
    parameter  int MAX_ATTEMPTS = 1023,
    localparam int XW = $clog2(BOARD_WIDTH),
    localparam int YW = $clog2(BOARD_HEIGHT),
    localparam int CW = $clog2(BOARD_WIDTH*BOARD_HEIGHT+1),
    localparam int AW = $clog2(MAX_ATTEMPTS+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  ack,
    input  logic [CW-1:0]         totalMinesIn,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  safeEn,
    input  logic [XW-1:0]         safeX,
    input  logic [YW-1:0]         safeY,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    input  logic                  mineBoardReadValue,
    output logic                  placeMineEn,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CW-1:0]         placedCount
);

    localparam int CELLS    = BOARD_WIDTH * BOARD_HEIGHT;
    localparam int SQUARE   = (2*SAFE_RADIUS+1) * (2*SAFE_RADIUS+1);
    localparam int CAP_SAFE = (CELLS > SQUARE) ? CELLS - SQUARE : 0;

    state_t                  state;
    logic [LFSR_WIDTH-1:0]   lfsr_val;
    logic [CW-1:0]           target;
    logic [CW-1:0]           cap;
    logic [CW-1:0]           clamped;
    // One spare bit so a draw after an accept at the budget edge cannot wrap.
    logic [AW:0]             attempts;
    logic                    safe_en_q;
    logic [XW-1:0]           safe_x_q;
    logic [YW-1:0]           safe_y_q;
    logic                    in_bounds;
    logic                    in_safe;
    logic                    reject;
    int                      dx;
    int                      dy;

    mine_lfsr #(.WIDTH(LFSR_WIDTH)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_IDLE && start),
        .seed  (seed),
        .step  (state == S_GEN),
        .value (lfsr_val)
    );

    assign cap     = safeEn ? CW'(CAP_SAFE) : CW'(CELLS);
    assign clamped = (totalMinesIn > cap) ? cap : totalMinesIn;

    always_comb begin
        dx        = int'(x) - int'(safe_x_q);
        dy        = int'(y) - int'(safe_y_q);
        in_bounds = (int'(x) < BOARD_WIDTH) && (int'(y) < BOARD_HEIGHT);
        in_safe   = safe_en_q && (dx >= -SAFE_RADIUS) && (dx <= SAFE_RADIUS)
                              && (dy >= -SAFE_RADIUS) && (dy <= SAFE_RADIUS);
        reject    = !in_bounds || in_safe || mineBoardReadValue;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            placeMineEn <= 1'b0;
            timeout     <= 1'b0;
            placedCount <= '0;
            target      <= '0;
            attempts    <= '0;
            safe_en_q   <= 1'b0;
            safe_x_q    <= '0;
            safe_y_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    safe_en_q   <= safeEn;
                    safe_x_q    <= safeX;
                    safe_y_q    <= safeY;
                    target      <= clamped;
                    attempts    <= '0;
                    placedCount <= '0;
                    timeout     <= 1'b0;
                    state       <= (clamped == '0) ? S_DONE : S_GEN;
                end
                S_GEN: begin
                    x        <= lfsr_val[XW-1:0];
                    y        <= lfsr_val[XW+YW-1:XW];
                    attempts <= attempts + 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (reject) begin
                        if (int'(attempts) >= MAX_ATTEMPTS) begin
                            timeout <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state   <= S_GEN;
                        end
                    end else begin
                        placeMineEn <= 1'b1;
                        placedCount <= placedCount + 1'b1;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    placeMineEn <= 1'b0;
                    state       <= (placedCount == target) ? S_DONE : S_GEN;
                end
                S_DONE: if (ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_place_mines_safe.sv
// Randomized bench for place_mines_safe: three configurations share stimulus,
// each run is predicted by a draw-by-draw reference model of the placer rules.
module tb_place_mines_safe;

    logic        clk = 1'b0;
    logic        reset, ack;
    logic [2:0]  start;
    logic [6:0]  tot;
    logic [15:0] seed;
    logic        safe_en;
    logic [2:0]  sx, sy;
    logic [2:0]  xo [3];
    logic [2:0]  yo [3];
    logic        pme [3];
    logic        bsy [3];
    logic        dn  [3];
    logic        tmo [3];
    logic        rd  [3];
    logic [6:0]  pc  [3];
    logic [4:0]  pc_b;
    bit          brd [3][8][8];
    int          nvec = 0;
    int          nerr = 0;
    int          got_q[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) rd[i] = brd[i][yo[i]][xo[i]];
    end

    // a: 8x8 default budget, b: 5x6 non-power-of-two, c: 8x8 with 16 draws
    place_mines_safe #(.BOARD_WIDTH(8), .BOARD_HEIGHT(8), .LFSR_WIDTH(16),
                       .SAFE_RADIUS(1), .MAX_ATTEMPTS(1023)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .ack(ack),
        .totalMinesIn(tot), .seed(seed), .safeEn(safe_en), .safeX(sx), .safeY(sy),
        .x(xo[0]), .y(yo[0]), .mineBoardReadValue(rd[0]), .placeMineEn(pme[0]),
        .busy(bsy[0]), .done(dn[0]), .timeout(tmo[0]), .placedCount(pc[0]));

    place_mines_safe #(.BOARD_WIDTH(5), .BOARD_HEIGHT(6), .LFSR_WIDTH(16),
                       .SAFE_RADIUS(1), .MAX_ATTEMPTS(1023)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .ack(ack),
        .totalMinesIn(tot[4:0]), .seed(seed), .safeEn(safe_en), .safeX(sx), .safeY(sy),
        .x(xo[1]), .y(yo[1]), .mineBoardReadValue(rd[1]), .placeMineEn(pme[1]),
        .busy(bsy[1]), .done(dn[1]), .timeout(tmo[1]), .placedCount(pc_b));

    assign pc[1] = {2'b00, pc_b};

    place_mines_safe #(.BOARD_WIDTH(8), .BOARD_HEIGHT(8), .LFSR_WIDTH(16),
                       .SAFE_RADIUS(1), .MAX_ATTEMPTS(16)) dut_c (
        .clk(clk), .reset(reset), .start(start[2]), .ack(ack),
        .totalMinesIn(tot), .seed(seed), .safeEn(safe_en), .safeX(sx), .safeY(sy),
        .x(xo[2]), .y(yo[2]), .mineBoardReadValue(rd[2]), .placeMineEn(pme[2]),
        .busy(bsy[2]), .done(dn[2]), .timeout(tmo[2]), .placedCount(pc[2]));

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned v);
        return (v >> 1) ^ (((v & 1) != 0) ? 32'h0000_B400 : 32'h0);
    endfunction

    // instance c models a board that is already full
    task automatic clr(input int s);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) brd[s][i][j] = (s == 2);
    endtask

    task automatic run(input int s, input logic [15:0] sd, input int req,
                       input bit en, input int cx, input int cy, input bit hold);
        int W, H, MX, cap, tgt, att, np, ecyc, cyc, to, bad, pcg;
        int unsigned v;
        bit etmo;
        bit mb [8][8];
        int exp_q[$];
        W  = (s == 1) ? 5 : 8;
        H  = (s == 1) ? 6 : 8;
        MX = (s == 2) ? 16 : 1023;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mb[i][j] = brd[s][i][j];
        cap = en ? W*H - 9 : W*H;
        tgt = (req < cap) ? req : cap;
        v = (sd == 0) ? 1 : int'(sd);
        att = 0; np = 0; ecyc = 0; etmo = 0;
        while (np < tgt) begin
            int ux, uy;
            bit rej;
            ux = int'(v & 7);
            uy = int'((v >> 3) & 7);
            v = lfsr_next(v);
            att++;
            rej = (ux >= W) || (uy >= H) ||
                  (en && (ux - cx <= 1) && (cx - ux <= 1) && (uy - cy <= 1) && (cy - uy <= 1)) ||
                  mb[uy][ux];
            if (rej) begin
                ecyc += 2;
                if (att >= MX) begin etmo = 1; break; end
            end else begin
                ecyc += 3;
                mb[uy][ux] = 1;
                exp_q.push_back(uy*8 + ux);
                np++;
            end
        end

        @(negedge clk);
        seed = sd; tot = 7'(req); safe_en = en; sx = 3'(cx); sy = 3'(cy);
        start[s] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start[s] = 1'b0;
        got_q.delete();
        cyc = 0; to = 0;
        forever begin
            @(negedge clk);
            if (dn[s]) break;
            if (pme[s]) begin
                got_q.push_back(int'(yo[s])*8 + int'(xo[s]));
                brd[s][yo[s]][xo[s]] = 1'b1;
            end
            cyc++;
            if (cyc > 4000) begin to = 1; break; end
        end
        chk("done_reached", to, 0);
        chk("cycles", cyc, ecyc);
        chk("nwrites", got_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) bad++;
        chk("cells", bad, 0);
        chk("placed", int'(pc[s]), np);
        chk("timeout", int'(tmo[s]), int'(etmo));
        chk("busy_in_done", int'(bsy[s]), 1);
        pcg = int'(pc[s]);
        if (hold) begin
            repeat (4) @(negedge clk);
            chk("hold_done", int'(dn[s]), 1);
            chk("hold_placed", int'(pc[s]), pcg);
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        start[s] = 1'b0;
        @(negedge clk);
        chk("done_fall", int'(dn[s]), 0);
        chk("idle", int'(bsy[s]), 0);
        @(negedge clk);
        chk("stay_idle", int'(bsy[s]), 0);
    endtask

    initial begin
        int q0[$];
        int part[$];
        int bad, n;
        reset = 1'b1; ack = 1'b0; start = '0; tot = '0; seed = '0;
        safe_en = 1'b0; sx = '0; sy = '0;
        for (int s = 0; s < 3; s++) clr(s);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(xo[0]), 0);
        chk("rst_y", int'(yo[0]), 0);
        chk("rst_pme", int'(pme[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_timeout", int'(tmo[0]), 0);
        chk("rst_placed", int'(pc[0]), 0);
        @(negedge clk);
        reset = 1'b0;

        clr(0); run(0, 16'hACE1, 10, 0, 0, 0, 0);
        chk("basic_placed", int'(pc[0]), 10);

        clr(0); run(0, 16'(($urandom & 16'hFFFF) | 1), 40, 1, 0, 0, 0);
        chk("safe_placed", int'(pc[0]), 40);

        clr(1); run(1, 16'hACE1, 31, 1, 2, 3, 0);
        chk("clamp_placed", int'(pc[1]), 21);

        clr(2); run(2, 16'($urandom), 3, 0, 0, 0, 0);
        chk("to_flag", int'(tmo[2]), 1);

        clr(0); run(0, 16'h5A5A, 0, 0, 0, 0, 0);

        clr(0); run(0, 16'h0000, 12, 0, 0, 0, 1);
        q0 = got_q;
        clr(0); run(0, 16'h0001, 12, 0, 0, 0, 0);
        bad = (q0.size() == got_q.size()) ? 0 : 1;
        for (int i = 0; i < q0.size() && i < got_q.size(); i++)
            if (q0[i] != got_q[i]) bad++;
        chk("seed0_eq_seed1", bad, 0);

        // reset on the third WRITE cycle
        clr(0);
        @(negedge clk);
        seed = 16'h1234; tot = 7'd20; safe_en = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        part.delete(); n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (pme[0]) begin
                part.push_back(int'(yo[0])*8 + int'(xo[0]));
                if (part.size() == 3) break;
            end
            n++;
        end
        chk("reach_write", part.size(), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_x", int'(xo[0]), 0);
        chk("mid_rst_y", int'(yo[0]), 0);
        chk("mid_rst_pme", int'(pme[0]), 0);
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_done", int'(dn[0]), 0);
        chk("mid_rst_placed", int'(pc[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        clr(0); run(0, 16'h1234, 20, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < part.size() && i < got_q.size(); i++)
            if (part[i] != got_q[i]) bad++;
        chk("reset_replay", bad, 0);

        for (int k = 0; k < 8; k++) begin
            int s;
            s = int'($urandom_range(0, 1));
            clr(s);
            run(s, 16'($urandom),
                (s == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 64)),
                bit'($urandom_range(0, 1)),
                int'($urandom_range(0, (s == 1) ? 4 : 7)),
                int'($urandom_range(0, (s == 1) ? 5 : 7)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
